// File: rtl/mips_pkg.sv
// Shared encodings for the fetch front end: redirect selects, sequencer states
// and the default reset PC.
package mips_pkg;

  localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;

  typedef enum logic [1:0] {
    SEL_NONE = 2'b00,
    SEL_BEQ  = 2'b01,
    SEL_J    = 2'b10,
    SEL_JR   = 2'b11
  } redir_sel_e;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_HOLD  = 2'd1,
    ST_DRAIN = 2'd2
  } seq_state_e;

  // beq only transfers control when the ALU reports equality
  function automatic logic redirect_taken(input logic vld, input logic [1:0] sel,
                                          input logic zero);
    return vld && ((sel == SEL_J) || (sel == SEL_JR) || ((sel == SEL_BEQ) && zero));
  endfunction

endpackage

// File: rtl/branch_target.sv
// Stateless control-transfer target computation for beq, j/jal and jr.
module branch_target
  import mips_pkg::*;
(
  input  logic [1:0]  sel,
  input  logic [31:0] instr,
  input  logic [31:0] pc,
  input  logic [31:0] rs_data,
  output logic [31:0] target
);

  logic [31:0] pc4;
  logic        unused_ok;

  assign pc4       = pc + 32'd4;
  assign unused_ok = ^{instr[31:26], rs_data[1:0]};

  always_comb begin
    target = pc4;
    case (redir_sel_e'(sel))
      SEL_BEQ: target = pc4 + {{14{instr[15]}}, instr[15:0], 2'b00};
      SEL_J:   target = {pc4[31:28], instr[25:0], 2'b00};
      SEL_JR:  target = {rs_data[31:2], 2'b00};
      default: target = pc4;
    endcase
  end

endmodule

// File: rtl/pc_sequencer.sv
// Instruction fetch sequencer: issues imem reads, holds one fetched instruction
// for decode, and handles redirects including draining an in-flight read.
module pc_sequencer
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect_valid,
  input  logic [1:0]  redirect_sel,
  input  logic        zero,
  input  logic [31:0] rs_data,
  input  logic [31:0] redirect_instr,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic        addr_err,
  output logic [15:0] flush_cnt
);

  seq_state_e  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] tgt_q, tgt_d;
  logic [31:0] target;
  logic        eff, cap, flush_inc;

  branch_target u_tgt (
    .sel     (redirect_sel),
    .instr   (redirect_instr),
    .pc      (redirect_pc),
    .rs_data (rs_data),
    .target  (target)
  );

  assign eff       = redirect_taken(redirect_valid, redirect_sel, zero);
  // pc only moves on ack or in HOLD, so the address stays put for the whole request
  assign imem_addr = pc_q;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    tgt_d     = tgt_q;
    cap       = 1'b0;
    flush_inc = 1'b0;
    imem_req  = 1'b0;
    if_valid  = 1'b0;
    case (state_q)
      ST_FETCH: begin
        imem_req = 1'b1;
        if (eff && imem_ack) begin
          pc_d      = target;
          flush_inc = 1'b1;
        end else if (eff) begin
          tgt_d   = target;
          state_d = ST_DRAIN;
        end else if (imem_ack) begin
          cap     = 1'b1;
          pc_d    = pc_q + 32'd4;
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if_valid = 1'b1;
        if (eff) begin
          pc_d      = target;
          flush_inc = 1'b1;
          state_d   = ST_FETCH;
        end else if (if_ready) begin
          state_d = ST_FETCH;
        end
      end
      ST_DRAIN: begin
        imem_req = 1'b1;
        if (eff) tgt_d = target;
        if (imem_ack) begin
          pc_d      = eff ? target : tgt_q;
          flush_inc = 1'b1;
          state_d   = ST_FETCH;
        end
      end
      default: state_d = ST_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_FETCH;
      pc_q      <= RESET_PC;
      tgt_q     <= '0;
      if_instr  <= '0;
      if_pc     <= '0;
      addr_err  <= 1'b0;
      flush_cnt <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      tgt_q    <= tgt_d;
      addr_err <= eff && (redirect_sel == SEL_JR) && (rs_data[1:0] != 2'b00);
      if (cap) begin
        if_instr <= imem_rdata;
        if_pc    <= pc_q;
      end
      if (flush_inc && (flush_cnt != 16'hFFFF)) flush_cnt <= flush_cnt + 16'd1;
    end
  end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_3000, the address of the first fetch after reset.
REQ-002 SHALL have one clock; reset is synchronous and active-low, ports named as follows.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 rst_n  in  1  synchronous active-low reset.
REQ-005 redirect_valid  in  1  decode requests a control transfer this cycle.
REQ-006 redirect_sel  in  2  00 none, 01 beq, 10 j/jal, 11 jr.
REQ-007 zero  in  1  ALU equality result for beq.
REQ-008 rs_data  in  32  register value for jr.
REQ-009 redirect_instr  in  32  instruction word of the redirecting instruction.
REQ-010 redirect_pc  in  32  PC of the redirecting instruction.
REQ-011 imem_req  out  1  instruction-memory read request.
REQ-012 imem_addr  out  32  read address.
REQ-013 imem_ack  in  1  read complete; imem_rdata valid this cycle.
REQ-014 imem_rdata  in  32  instruction word.
REQ-015 if_valid  out  1  if_instr/if_pc hold a fetched instruction.
REQ-016 if_ready  in  1  decode accepts the held instruction.
REQ-017 if_instr  out  32  fetched instruction.
REQ-018 if_pc  out  32  PC of if_instr.
REQ-019 addr_err  out  1  one-cycle pulse: misaligned jr target.
REQ-020 flush_cnt  out  16  count of discarded fetches.

Function
REQ-021 Redirect is effective only when redirect_valid=1 and (sel=10, sel=11, or sel=01 with zero=1); all other cases are ignored.
REQ-022 Targets: beq = redirect_pc+4+(sext(instr[15:0])<<2); j = {(redirect_pc+4)[31:28], instr[25:0], 2'b00}; jr = {rs_data[31:2], 2'b00}; all arithmetic modulo 2^32.
REQ-023 jr with rs_data[1:0]!=0 SHALL pulse addr_err for the cycle after the redirect and still redirect to the aligned target.
REQ-024 FSM states: FETCH (imem_req=1), HOLD (if_valid=1), DRAIN (imem_req=1, returning data discarded).
REQ-025 imem_req and imem_addr SHALL remain stable from assertion until the imem_ack cycle inclusive.
REQ-026 FETCH, ack, no effective redirect: capture imem_rdata/imem_addr into if_instr/if_pc, pc<=pc+4, next state HOLD.
REQ-027 HOLD: a transfer is if_valid&if_ready with no effective redirect; on transfer, next state FETCH at pc, so there is one bubble per instruction.
REQ-028 HOLD, effective redirect (with or without if_ready): held instruction is flushed, if_valid=0 next cycle, pc<=target, next state FETCH, flush_cnt+1.
REQ-029 FETCH, effective redirect, no ack: latch target, next state DRAIN.
REQ-030 FETCH, effective redirect and ack in the same cycle: discard data, pc<=target, next state FETCH, flush_cnt+1.
REQ-031 DRAIN: keep the old address until ack, then discard data, flush_cnt+1, pc<=latched target, next state FETCH; a further redirect in DRAIN overwrites the latched target (latest wins).
REQ-032 flush_cnt SHALL saturate at 16'hFFFF.
REQ-033 Back-to-back redirects on consecutive cycles SHALL each be honoured under the rules above.

Reset
REQ-034 While rst_n=0 at a clock edge: state<=FETCH, pc<=RESET_PC, if_valid=0, if_instr=0, if_pc=0, addr_err=0, flush_cnt=0.
REQ-035 Reset mid-fetch SHALL abandon the outstanding request without draining; memory SHALL tolerate the request being dropped.
REQ-036 In the first cycle after reset release, imem_req=1 and imem_addr=RESET_PC.

Structure
REQ-037 The redirect_sel encodings, FSM state encodings and RESET_PC default SHALL live in shared package mips_pkg.
REQ-038 Target computation SHALL be a combinational sub-module, branch_target, with no state; the FSM, pc register and counters stay in pc_sequencer.

Verification
REQ-039 Reset, ack after 2 cycles, if_ready=1 -> fetch addresses 0x3000, 0x3004, 0x3008; if_pc matches each address.
REQ-040 HOLD at if_pc=0x3010, beq imm=16'hFFFC, zero=1 -> if_valid drops, next imem_addr=0x3004, flush_cnt=1.
REQ-041 beq with zero=0 during HOLD -> no flush, sequential fetch continues, flush_cnt unchanged.
REQ-042 Redirect j instr[25:0]=0x0000100 during FETCH, ack delayed 3 cycles -> imem_addr held until ack, data discarded, next fetch 0x0000_0400.
REQ-043 jr rs_data=0x0000_3021 -> addr_err pulses once, next fetch 0x3020.
REQ-044 Two redirects in DRAIN (targets 0x3100, then 0x3200) -> single discard, next fetch 0x3200.
